// File: rtl/oled_init_seq_if.sv
// oled_init_seq_if -- byte-level link between the OLED init sequencer and the
// shared SPI byte transmitter.
//   spi_send : level request, spi_data/dc valid while high
//   spi_data : byte to shift out
//   dc       : 0 = command byte, 1 = display-data byte
//   spi_done : 1-cycle pulse from the transmitter, current byte finished
// master = sequencer side, slave = transmitter side.
interface oled_init_seq_if;
    logic       spi_send;
    logic [7:0] spi_data;
    logic       dc;
    logic       spi_done;

    modport master (output spi_send, output spi_data, output dc, input spi_done);
    modport slave  (input spi_send, input spi_data, input dc, output spi_done);
endinterface

// File: rtl/oled_init_seq.sv
// oled_init_seq -- SSD1306 power-up sequencer.
// Drives panel reset and VBAT enable, then sends the init command list one byte
// at a time to the SPI byte transmitter. The transmitter belongs to this block
// until init_done goes high.
// Optional feature macro: OLED_CLEAR_EN. When it is defined, CLR_BYTES zero data
// bytes clear the display RAM after the last command.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   start       1-cycle pulse that re-runs the sequence; only accepted in S_DONE
//   spi         oled_init_seq_if.master (spi_send/spi_data/dc out, spi_done in)
//   res_n       panel reset, active low
//   vbat_n      VBAT enable, active low
//   init_done   high while the sequence is complete
module oled_init_seq #(
    parameter int unsigned RST_CYCLES        = 300,
    parameter int unsigned VBAT_DELAY_CYCLES = 10_000_000,
    parameter logic [7:0]  CONTRAST          = 8'hCF,
    parameter bit          SEG_REMAP         = 1'b0,
    parameter int unsigned CLR_BYTES         = 512
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    oled_init_seq_if.master        spi,
    output logic                   res_n,
    output logic                   vbat_n,
    output logic                   init_done
);

    // Each timed state counts 0..LAST, which gives N cycles in the state.
    // A delay of 0 is treated as 1.
    localparam logic [31:0] RST_LAST  = (RST_CYCLES > 1) ? 32'(RST_CYCLES - 1) : 32'd0;
    localparam logic [31:0] VBAT_LAST = (VBAT_DELAY_CYCLES > 1) ? 32'(VBAT_DELAY_CYCLES - 1) : 32'd0;

    typedef enum logic [2:0] {
        S_RST_LO,
        S_RST_HI,
        S_CMD,
        S_VBAT,
`ifdef OLED_CLEAR_EN
        S_CLEAR,
`endif
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  idx, idx_nxt;
    logic [31:0] timer, timer_nxt;
    logic        send_nxt, dc_nxt, res_n_nxt, vbat_n_nxt, init_done_nxt;
    logic [7:0]  data_nxt;
    logic        byte_done;

`ifdef OLED_CLEAR_EN
    localparam logic [31:0] CLR_LAST = (CLR_BYTES > 1) ? 32'(CLR_BYTES - 1) : 32'd0;
    logic [31:0] clr_cnt, clr_cnt_nxt;
`endif

    // Init command table. Entries 0..4 come before VBAT is enabled.
    function automatic logic [7:0] cmd_byte(input logic [3:0] i);
        case (i)
            4'd0:    cmd_byte = 8'hAE;   // display off
            4'd1:    cmd_byte = 8'hD5;   // clock divide
            4'd2:    cmd_byte = 8'h80;
            4'd3:    cmd_byte = 8'h8D;   // charge pump
            4'd4:    cmd_byte = 8'h14;
            4'd5:    cmd_byte = 8'h81;   // contrast
            4'd6:    cmd_byte = CONTRAST;
            4'd7:    cmd_byte = 8'hD9;   // pre-charge
            4'd8:    cmd_byte = 8'hF1;
            4'd9:    cmd_byte = 8'h20;   // addressing mode
            4'd10:   cmd_byte = 8'h00;
            4'd11:   cmd_byte = SEG_REMAP ? 8'hA1 : 8'hA0;
            default: cmd_byte = 8'hAF;   // display on
        endcase
    endfunction

    // A spi_done only counts while a byte is actually being requested.
    assign byte_done = spi.spi_send && spi.spi_done;

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        timer_nxt  = timer;
        vbat_n_nxt = vbat_n;
`ifdef OLED_CLEAR_EN
        clr_cnt_nxt = clr_cnt;
`endif
        case (state)
            S_RST_LO: begin
                if (timer == RST_LAST) begin
                    state_nxt = S_RST_HI;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 32'd1;
                end
            end
            S_RST_HI: begin
                if (timer == RST_LAST) begin
                    state_nxt = S_CMD;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 32'd1;
                end
            end
            S_CMD: begin
                if (byte_done) begin
                    if (idx == 4'd4) begin
                        idx_nxt   = 4'd5;
                        state_nxt = S_VBAT;
                    end else if (idx == 4'd12) begin
`ifdef OLED_CLEAR_EN
                        state_nxt   = S_CLEAR;
                        clr_cnt_nxt = '0;
`else
                        state_nxt = S_DONE;
`endif
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
            end
            S_VBAT: begin
                if (timer == VBAT_LAST) begin
                    state_nxt = S_CMD;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 32'd1;
                end
            end
`ifdef OLED_CLEAR_EN
            S_CLEAR: begin
                if (byte_done) begin
                    if (clr_cnt == CLR_LAST) state_nxt = S_DONE;
                    else                     clr_cnt_nxt = clr_cnt + 32'd1;
                end
            end
`endif
            S_DONE: begin
                if (start) begin
                    state_nxt  = S_RST_LO;
                    idx_nxt    = '0;
                    timer_nxt  = '0;
                    vbat_n_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = S_RST_LO;
                idx_nxt   = '0;
                timer_nxt = '0;
            end
        endcase

        // VBAT stays enabled from here until reset or start.
        if (state_nxt == S_VBAT) vbat_n_nxt = 1'b0;

        // Outputs are a function of the next state, so they change on the same
        // edge as the state register and stay fully registered.
        send_nxt      = (state_nxt == S_CMD);
        dc_nxt        = 1'b0;
        data_nxt      = (state_nxt == S_CMD) ? cmd_byte(idx_nxt) : 8'h00;
`ifdef OLED_CLEAR_EN
        if (state_nxt == S_CLEAR) begin
            send_nxt = 1'b1;
            dc_nxt   = 1'b1;
        end
`endif
        res_n_nxt     = (state_nxt != S_RST_LO);
        init_done_nxt = (state_nxt == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_RST_LO;
            idx          <= '0;
            timer        <= '0;
            spi.spi_send <= 1'b0;
            spi.spi_data <= 8'h00;
            spi.dc       <= 1'b0;
            res_n        <= 1'b0;
            vbat_n       <= 1'b1;
            init_done    <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            timer        <= timer_nxt;
            spi.spi_send <= send_nxt;
            spi.spi_data <= data_nxt;
            spi.dc       <= dc_nxt;
            res_n        <= res_n_nxt;
            vbat_n       <= vbat_n_nxt;
            init_done    <= init_done_nxt;
        end
    end

`ifdef OLED_CLEAR_EN
    always_ff @(posedge clk) begin
        if (reset) clr_cnt <= '0;
        else       clr_cnt <= clr_cnt_nxt;
    end
`endif

endmodule

// File: tb/tb_oled_init_seq.sv
// tb_oled_init_seq -- scoreboard bench for oled_init_seq.
// dut  : default CONTRAST/SEG_REMAP, full scoreboard on every transmitted byte.
// dut2 : CONTRAST=7F, SEG_REMAP=1, first command pass captured and spot-checked.
module tb_oled_init_seq;

    logic clk = 1'b0;
    logic reset;
    logic start;
    always #5 clk = ~clk;

    oled_init_seq_if s1();
    oled_init_seq_if s2();
    logic res_n1, vbat_n1, init_done1;
    logic res_n2, vbat_n2, init_done2;

    oled_init_seq #(.RST_CYCLES(4), .VBAT_DELAY_CYCLES(20), .CLR_BYTES(8)) dut (
        .clk(clk), .reset(reset), .start(start), .spi(s1),
        .res_n(res_n1), .vbat_n(vbat_n1), .init_done(init_done1)
    );

    oled_init_seq #(.RST_CYCLES(4), .VBAT_DELAY_CYCLES(20), .CONTRAST(8'h7F),
                    .SEG_REMAP(1'b1), .CLR_BYTES(8)) dut2 (
        .clk(clk), .reset(reset), .start(start), .spi(s2),
        .res_n(res_n2), .vbat_n(vbat_n2), .init_done(init_done2)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [8:0] exp_q[$];          // {dc, data} expected from dut
    int         cyc = 0;
    int         last_done_cyc = 0;
    int         cnt1 = 0, cnt2 = 0, n2 = 0;
    logic       model_done = 1'b0, done2 = 1'b0, stray_done;
    logic [7:0] cap2 [13];

    assign s1.spi_done = model_done | stray_done;
    assign s2.spi_done = done2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_seq();
        logic [7:0] tbl [13];
        tbl = '{8'hAE, 8'hD5, 8'h80, 8'h8D, 8'h14, 8'h81, 8'hCF,
                8'hD9, 8'hF1, 8'h20, 8'h00, 8'hA0, 8'hAF};
        foreach (tbl[i]) exp_q.push_back({1'b0, tbl[i]});
`ifdef OLED_CLEAR_EN
        repeat (8) exp_q.push_back(9'h100);
`endif
    endtask

    // SPI transmitter model: spi_done on the 3rd cycle of each byte.
    always @(negedge clk) begin
        if (s1.spi_send) begin
            cnt1 = cnt1 + 1;
            if (cnt1 == 3) begin
                model_done = 1'b1;
                cnt1 = 0;
                last_done_cyc = cyc;
                if (exp_q.size() == 0) chk("sb_unexpected", 32'(exp_q.size()), 32'd1);
                else chk("sb_byte", {23'd0, s1.dc, s1.spi_data}, {23'd0, exp_q.pop_front()});
            end else begin
                model_done = 1'b0;
            end
        end else begin
            cnt1 = 0;
            model_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (s2.spi_send) begin
            cnt2 = cnt2 + 1;
            if (cnt2 == 3) begin
                done2 = 1'b1;
                cnt2 = 0;
                if (n2 < 13) begin
                    cap2[n2] = s2.spi_data;
                    n2 = n2 + 1;
                end
            end else begin
                done2 = 1'b0;
            end
        end else begin
            cnt2 = 0;
            done2 = 1'b0;
        end
    end

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!init_done1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, init_done1, 1);
        chk("done_latency", 32'(cyc - last_done_cyc), 1);
        chk("sb_drain", 32'(exp_q.size()), 0);
        chk("send_idle", s1.spi_send, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_send"},  s1.spi_send, 0);
        chk({tag, "_data"},  s1.spi_data, 0);
        chk({tag, "_dc"},    s1.dc, 0);
        chk({tag, "_res_n"}, res_n1, 0);
        chk({tag, "_vbat"},  vbat_n1, 1);
        chk({tag, "_done"},  init_done1, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");

        // Run 1: reset release, timing of res_n, VBAT delay, stray inputs.
        push_seq();
        reset = 1'b0;
        n = 0;
        while (!res_n1 && n < 50) begin n++; @(negedge clk); end
        chk("res_lo_cycles", n, 4);
        n = 0;
        while (!s1.spi_send && n < 50) begin n++; @(negedge clk); end
        chk("res_hi_cycles", n, 4);

        n = 0;
        while (vbat_n1 && n < 500) begin n++; @(negedge clk); end
        chk("vbat_fall", vbat_n1, 0);
        n = 0;
        while (!s1.spi_send && n < 100) begin
            stray_done = (n == 5);       // must be ignored while idle in S_VBAT
            n++;
            @(negedge clk);
        end
        stray_done = 1'b0;
        chk("vbat_wait", n, 20);
        start = 1'b1;                    // must be ignored in S_CMD
        @(negedge clk);
        start = 1'b0;
        wait_init("run1_done");

        // Run 2: start from S_DONE repeats everything.
        push_seq();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_done", init_done1, 0);
        chk("start_vbat", vbat_n1, 1);
        chk("start_res_n", res_n1, 0);
        wait_init("run2_done");

        // Run 3: reset right after the 6th spi_done, then replay.
        push_seq();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        begin
            int t;
            t = 0;
            while (n < 6 && t < 2000) begin
                @(posedge clk);
                t++;
                if (s1.spi_done) n++;
            end
        end
        chk("six_dones", n, 6);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        exp_q.delete();
        push_seq();
        reset = 1'b0;
        wait_init("run3_done");

        chk("contrast_byte", cap2[6], 8'h7F);
        chk("segremap_byte", cap2[11], 8'hA1);
        chk("dut2_bytes", n2, 13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
